// File: rtl/heat_stencil_engine_pkg.sv
// Shared types and helpers for the heat stencil engine.
package heat_pkg;

    // Engine control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        CHECK = 2'd2
    } heat_state_e;

    // Edge handling modes selected by bc_mode.
    localparam logic BC_DIRICHLET = 1'b0;
    localparam logic BC_NEUMANN   = 1'b1;

    // Saturate a signed value into [0, hi_lim].
    function automatic int clamp_to_range(input int value, input int hi_lim);
        int res;
        if (value < 32'sd0) begin
            res = 32'sd0;
        end else if (value > hi_lim) begin
            res = hi_lim;
        end else begin
            res = value;
        end
        return res;
    endfunction

endpackage

// File: rtl/heat_stencil_pe.sv
// Combinational 5-point stencil cell: (C, L, R, U, D, alpha) -> new value.
module heat_stencil_pe
    import heat_pkg::*;
#(
    parameter int TEMP_W  = 4,
    parameter int ALPHA_W = 3
) (
    input  logic [TEMP_W-1:0]  c,
    input  logic [TEMP_W-1:0]  l,
    input  logic [TEMP_W-1:0]  r,
    input  logic [TEMP_W-1:0]  u,
    input  logic [TEMP_W-1:0]  d,
    input  logic [ALPHA_W-1:0] alpha,
    output logic [TEMP_W-1:0]  new_val
);

    // Product width holds |lap| * alpha with a sign bit to spare.
    localparam int PW   = TEMP_W + ALPHA_W + 2;
    localparam int TMAX = (32'sd1 <<< TEMP_W) - 32'sd1;

    logic [TEMP_W+1:0]      sum_s;
    logic [TEMP_W-1:0]      avg_s;
    logic signed [PW-1:0]   lap_s;
    logic signed [PW-1:0]   coef_s;
    logic signed [PW-1:0]   prod_s;
    logic signed [PW-1:0]   delta_s;
    logic signed [PW:0]     raw_s;

    // Neighbour average, scaled Laplacian with floor shift, then saturation.
    always_comb begin
        sum_s   = {2'b00, l} + {2'b00, r} + {2'b00, u} + {2'b00, d};
        avg_s   = sum_s[TEMP_W+1:2];
        lap_s   = $signed({{(PW-TEMP_W){1'b0}}, avg_s}) - $signed({{(PW-TEMP_W){1'b0}}, c});
        coef_s  = $signed({{(PW-ALPHA_W){1'b0}}, alpha});
        prod_s  = lap_s * coef_s;
        delta_s = prod_s >>> 3'd3;
        raw_s   = $signed({delta_s[PW-1], delta_s}) + $signed({{(PW+1-TEMP_W){1'b0}}, c});
        new_val = TEMP_W'(clamp_to_range(int'(raw_s), TMAX));
    end

endmodule

// File: rtl/heat_stencil_engine.sv
// In-place Gauss-Seidel heat solver over a register grid, one cell per clock.
module heat_stencil_engine
    import heat_pkg::*;
#(
    parameter int GRID_W  = 6,
    parameter int GRID_H  = 6,
    parameter int TEMP_W  = 4,
    parameter int ALPHA_W = 3,
    parameter int ITER_W  = 12,
    localparam int N      = GRID_W * GRID_H,
    localparam int AW     = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [ITER_W-1:0]  n_iter,
    input  logic [ALPHA_W-1:0] alpha,
    input  logic [TEMP_W-1:0]  conv_thresh,
    input  logic               bc_mode,
    input  logic [TEMP_W-1:0]  bnd_top,
    input  logic [TEMP_W-1:0]  bnd_bottom,
    input  logic [TEMP_W-1:0]  bnd_left,
    input  logic [TEMP_W-1:0]  bnd_right,
    input  logic               host_we,
    input  logic [AW-1:0]      host_addr,
    input  logic [TEMP_W-1:0]  host_wdata,
    output logic [TEMP_W-1:0]  host_rdata,
    output logic               busy,
    output logic               done,
    output logic               converged,
    output logic [ITER_W-1:0]  iter_count,
    output logic [TEMP_W-1:0]  max_delta
);

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam logic [XW-1:0]     X_LAST   = XW'(GRID_W - 1);
    localparam logic [YW-1:0]     Y_LAST   = YW'(GRID_H - 1);
    localparam logic [AW-1:0]     IDX_ONE  = AW'(1);
    localparam logic [AW-1:0]     IDX_ROW  = AW'(GRID_W);
    localparam logic [AW:0]       N_CELLS  = (AW+1)'(N);
    localparam logic [ITER_W-1:0] ITER_ONE = ITER_W'(1);

    heat_state_e        state_r, state_nx_s;
    logic [TEMP_W-1:0]  grid_r [N];
    logic [XW-1:0]      x_r;
    logic [YW-1:0]      y_r;
    logic [AW-1:0]      idx_r;
    logic [TEMP_W-1:0]  sweep_max_r, max_delta_r, host_rdata_r;
    logic [ITER_W-1:0]  iter_count_r;
    logic               converged_r, done_r, busy_r;

    logic [TEMP_W-1:0]  c_s, l_s, r_s, u_s, d_s, pe_new_s, bnd_val_s, wval_s, diff_s;
    logic               edge_s, last_cell_s, conv_hit_s, limit_hit_s;
    logic               start_run_s, cell_we_s, check_s, finish_s;

    // Neighbour fetch; an off-grid neighbour is replaced by the centre cell.
    always_comb begin
        c_s = grid_r[idx_r];
        l_s = (x_r == {XW{1'b0}}) ? c_s : grid_r[idx_r - IDX_ONE];
        r_s = (x_r == X_LAST)     ? c_s : grid_r[idx_r + IDX_ONE];
        u_s = (y_r == {YW{1'b0}}) ? c_s : grid_r[idx_r - IDX_ROW];
        d_s = (y_r == Y_LAST)     ? c_s : grid_r[idx_r + IDX_ROW];
    end

    heat_stencil_pe #(
        .TEMP_W  (TEMP_W),
        .ALPHA_W (ALPHA_W)
    ) u_pe (
        .c       (c_s),
        .l       (l_s),
        .r       (r_s),
        .u       (u_s),
        .d       (d_s),
        .alpha   (alpha),
        .new_val (pe_new_s)
    );

    // Value written back for the current cell and its change magnitude.
    always_comb begin
        edge_s = (y_r == {YW{1'b0}}) || (y_r == Y_LAST) || (x_r == {XW{1'b0}}) || (x_r == X_LAST);
        if (y_r == {YW{1'b0}}) begin
            bnd_val_s = bnd_top;
        end else if (y_r == Y_LAST) begin
            bnd_val_s = bnd_bottom;
        end else if (x_r == {XW{1'b0}}) begin
            bnd_val_s = bnd_left;
        end else begin
            bnd_val_s = bnd_right;
        end
        wval_s      = ((bc_mode == BC_DIRICHLET) && edge_s) ? bnd_val_s : pe_new_s;
        diff_s      = (wval_s >= c_s) ? (wval_s - c_s) : (c_s - wval_s);
        last_cell_s = (x_r == X_LAST) && (y_r == Y_LAST);
        conv_hit_s  = (sweep_max_r <= conv_thresh);
        limit_hit_s = (n_iter != {ITER_W{1'b0}}) && ((iter_count_r + ITER_ONE) == n_iter);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; abort wins over sweep progress, start wins in IDLE.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE:    state_nx_s = start ? SWEEP : IDLE;
            SWEEP: begin
                if (abort) begin
                    state_nx_s = IDLE;
                end else if (last_cell_s) begin
                    state_nx_s = CHECK;
                end else begin
                    state_nx_s = SWEEP;
                end
            end
            CHECK: begin
                if (abort || conv_hit_s || limit_hit_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = SWEEP;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Per-state control strobes.
    always_comb begin
        start_run_s = 1'b0;
        cell_we_s   = 1'b0;
        check_s     = 1'b0;
        case (state_r)
            IDLE:    start_run_s = start;
            SWEEP:   cell_we_s   = ~abort;
            CHECK:   check_s     = ~abort;
            default: start_run_s = 1'b0;
        endcase
        finish_s = check_s && (conv_hit_s || limit_hit_s);
    end

    // Grid storage: host writes while idle, stencil writes during a sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                grid_r[i] <= {TEMP_W{1'b0}};
            end
        end else if (cell_we_s) begin
            grid_r[idx_r] <= wval_s;
        end else if ((state_r == IDLE) && host_we && ({1'b0, host_addr} < N_CELLS)) begin
            grid_r[host_addr] <= host_wdata;
        end else begin
            grid_r[0] <= grid_r[0];
        end
    end

    // Registered host read port; out-of-range addresses read as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            host_rdata_r <= {TEMP_W{1'b0}};
        end else if ({1'b0, host_addr} < N_CELLS) begin
            host_rdata_r <= grid_r[host_addr];
        end else begin
            host_rdata_r <= {TEMP_W{1'b0}};
        end
    end

    // Raster scan counters with wrap at the end of each row and sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r   <= {XW{1'b0}};
            y_r   <= {YW{1'b0}};
            idx_r <= {AW{1'b0}};
        end else if (start_run_s || (cell_we_s && last_cell_s)) begin
            x_r   <= {XW{1'b0}};
            y_r   <= {YW{1'b0}};
            idx_r <= {AW{1'b0}};
        end else if (cell_we_s) begin
            idx_r <= idx_r + IDX_ONE;
            if (x_r == X_LAST) begin
                x_r <= {XW{1'b0}};
                y_r <= y_r + YW'(1);
            end else begin
                x_r <= x_r + XW'(1);
            end
        end else begin
            idx_r <= idx_r;
        end
    end

    // Sweep max tracking, iteration bookkeeping and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sweep_max_r  <= {TEMP_W{1'b0}};
            max_delta_r  <= {TEMP_W{1'b0}};
            iter_count_r <= {ITER_W{1'b0}};
            converged_r  <= 1'b0;
            done_r       <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            done_r <= finish_s;
            busy_r <= (state_nx_s != IDLE);
            if (start_run_s) begin
                sweep_max_r  <= {TEMP_W{1'b0}};
                iter_count_r <= {ITER_W{1'b0}};
                converged_r  <= 1'b0;
            end else if (cell_we_s) begin
                sweep_max_r <= (diff_s > sweep_max_r) ? diff_s : sweep_max_r;
            end else if (check_s) begin
                iter_count_r <= iter_count_r + ITER_ONE;
                max_delta_r  <= sweep_max_r;
                sweep_max_r  <= {TEMP_W{1'b0}};
                converged_r  <= conv_hit_s;
            end else begin
                sweep_max_r <= sweep_max_r;
            end
        end
    end

    assign host_rdata = host_rdata_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign converged  = converged_r;
    assign iter_count = iter_count_r;
    assign max_delta  = max_delta_r;

endmodule

// File: tb/tb_heat_stencil_engine.sv
// Randomised self-checking bench for heat_stencil_engine against a Gauss-Seidel model.
module tb_heat_stencil_engine;

    localparam int GW = 6;
    localparam int GH = 6;
    localparam int TW = 4;
    localparam int AL = 4;
    localparam int IW = 12;
    localparam int N  = GW * GH;
    localparam int AW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst, start, abort, bc_mode, host_we;
    logic [IW-1:0] n_iter;
    logic [AL-1:0] alpha;
    logic [TW-1:0] conv_thresh, bnd_top, bnd_bottom, bnd_left, bnd_right, host_wdata;
    logic [AW-1:0] host_addr;
    logic [TW-1:0] host_rdata, max_delta;
    logic          busy, done, converged;
    logic [IW-1:0] iter_count;

    int n_cmp = 0;
    int n_err = 0;
    int mg[N];

    heat_stencil_engine #(
        .GRID_W(GW), .GRID_H(GH), .TEMP_W(TW), .ALPHA_W(AL), .ITER_W(IW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .n_iter(n_iter),
        .alpha(alpha), .conv_thresh(conv_thresh), .bc_mode(bc_mode),
        .bnd_top(bnd_top), .bnd_bottom(bnd_bottom), .bnd_left(bnd_left), .bnd_right(bnd_right),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .busy(busy), .done(done), .converged(converged),
        .iter_count(iter_count), .max_delta(max_delta)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference stencil written with plain integer arithmetic.
    function automatic int model_cell(int c, int l, int r, int u, int d, int al);
        int avg, lap, p, dl, nv;
        avg = (l + r + u + d) / 4;
        lap = avg - c;
        p   = lap * al;
        if (p >= 0) dl = p / 8;
        else        dl = -((-p + 7) / 8);
        nv = c + dl;
        if (nv < 0)  nv = 0;
        if (nv > 15) nv = 15;
        return nv;
    endfunction

    task automatic model_run(input int bc, input int al, input int th, input int ni,
                             input int bt, input int bb, input int bl, input int br,
                             output int iters, output int conv, output int md);
        iters = 0; conv = 0; md = 0;
        for (int g = 0; g < 4000; g++) begin
            int smax;
            smax = 0;
            for (int y = 0; y < GH; y++) begin
                for (int x = 0; x < GW; x++) begin
                    int i, c, nv, df;
                    i = y * GW + x;
                    c = mg[i];
                    if (bc == 0 && (y == 0 || y == GH-1 || x == 0 || x == GW-1)) begin
                        nv = (y == 0) ? bt : (y == GH-1) ? bb : (x == 0) ? bl : br;
                    end else begin
                        nv = model_cell(c, (x == 0) ? c : mg[i-1], (x == GW-1) ? c : mg[i+1],
                                        (y == 0) ? c : mg[i-GW], (y == GH-1) ? c : mg[i+GW], al);
                    end
                    df = (nv > c) ? nv - c : c - nv;
                    if (df > smax) smax = df;
                    mg[i] = nv;
                end
            end
            iters++;
            md = smax;
            if (smax <= th) begin conv = 1; break; end
            if (ni != 0 && iters == ni) break;
        end
    endtask

    task automatic host_write(input int a, input int v);
        @(negedge clk);
        host_we = 1'b1; host_addr = AW'(a); host_wdata = TW'(v);
        @(negedge clk);
        host_we = 1'b0;
        if (a < N) mg[a] = v;
    endtask

    task automatic host_read(input int a, output int v);
        @(negedge clk);
        host_addr = AW'(a);
        @(negedge clk);
        v = int'(host_rdata);
    endtask

    task automatic check_grid(input string tag);
        int v;
        for (int i = 0; i < N; i++) begin
            host_read(i, v);
            check_val($sformatf("%s cell%0d", tag, i), v, mg[i]);
        end
    endtask

    task automatic run_and_check(input string tag, input int bc, input int al, input int th, input int ni,
                                 input int bt, input int bb, input int bl, input int br, input bit ab_start);
        int eit, econv, emd, e;
        model_run(bc, al, th, ni, bt, bb, bl, br, eit, econv, emd);
        @(negedge clk);
        bc_mode = bc[0]; alpha = AL'(al); conv_thresh = TW'(th); n_iter = IW'(ni);
        bnd_top = TW'(bt); bnd_bottom = TW'(bb); bnd_left = TW'(bl); bnd_right = TW'(br);
        start = 1'b1; abort = ab_start;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        e = 1;
        check_val({tag, " busy_rise"}, busy, 1);
        while (done !== 1'b1 && e < 20000) begin
            @(negedge clk);
            e++;
        end
        check_val({tag, " done_cycle"}, e, eit * (N + 1) + 1);
        check_val({tag, " busy_fall"}, busy, 0);
        check_val({tag, " iter_count"}, iter_count, eit);
        check_val({tag, " converged"}, converged, econv);
        check_val({tag, " max_delta"}, max_delta, emd);
        @(negedge clk);
        check_val({tag, " done_pulse"}, done, 0);
        check_grid(tag);
    endtask

    initial begin
        int v, ndone;
        rst = 1'b1; start = 1'b0; abort = 1'b0; bc_mode = 1'b0; host_we = 1'b0;
        n_iter = '0; alpha = '0; conv_thresh = '0; host_addr = '0; host_wdata = '0;
        bnd_top = '0; bnd_bottom = '0; bnd_left = '0; bnd_right = '0;
        for (int i = 0; i < N; i++) mg[i] = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_val("rst busy", busy, 0);
        check_val("rst done", done, 0);
        check_val("rst converged", converged, 0);
        check_val("rst iter_count", iter_count, 0);
        check_val("rst max_delta", max_delta, 0);
        check_val("rst host_rdata", host_rdata, 0);
        check_grid("rst");

        // Dirichlet, alpha 0, hot top edge.
        run_and_check("dir_top", 0, 0, 0, 1, 15, 0, 0, 0, 1'b0);
        host_read(0, v);  check_val("dir_top corner0", v, 15);
        host_read(7, v);  check_val("dir_top cell7", v, 0);

        // Neumann single-pulse diffusion.
        for (int i = 0; i < N; i++) host_write(i, (i == 14) ? 15 : 0);
        run_and_check("neu_pulse", 1, 7, 0, 1, 0, 0, 0, 0, 1'b0);
        host_read(8, v);  check_val("neu_pulse cell8", v, 2);
        host_read(13, v); check_val("neu_pulse cell13", v, 2);
        host_read(14, v); check_val("neu_pulse cell14", v, 2);
        host_read(15, v); check_val("neu_pulse cell15", v, 0);
        check_val("neu_pulse md13", max_delta, 13);

        // Convergence with unbounded iteration limit.
        for (int i = 0; i < N; i++) host_write(i, 0);
        run_and_check("conv", 0, 3, 0, 0, 0, 0, 0, 0, 1'b0);
        check_val("conv flag", converged, 1);

        // Clamp at zero for a strongly negative delta.
        host_write(14, 15);
        run_and_check("clamp", 1, 15, 0, 1, 0, 0, 0, 0, 1'b0);
        host_read(14, v); check_val("clamp cell14", v, 0);

        // Randomised runs; one launches with abort held alongside start.
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < N; i++) host_write(i, $urandom_range(15, 0));
            run_and_check($sformatf("rnd%0d", k), $urandom_range(1, 0), $urandom_range(15, 0),
                          $urandom_range(15, 0), $urandom_range(3, 1),
                          $urandom_range(15, 0), $urandom_range(15, 0),
                          $urandom_range(15, 0), $urandom_range(15, 0), k == 2);
        end

        // Out-of-range write ignored and read as zero.
        host_write(40, 9);
        host_read(40, v); check_val("oor read", v, 0);
        check_grid("oor");

        // Same-cycle write and read returns the old value.
        v = (mg[5] + 7) % 16;
        @(negedge clk);
        host_addr = AW'(5); host_we = 1'b1; host_wdata = TW'(v);
        @(negedge clk);
        host_we = 1'b0;
        check_val("rw old", host_rdata, mg[5]);
        mg[5] = v;
        host_read(5, v); check_val("rw new", v, mg[5]);

        // Abort mid-sweep; a host write while busy must be dropped.
        for (int i = 0; i < N; i++) host_write(i, 0);
        ndone = 0;
        @(negedge clk);
        bc_mode = 1'b0; alpha = AL'(5); conv_thresh = '0; n_iter = IW'(2);
        bnd_top = '0; bnd_bottom = '0; bnd_left = '0; bnd_right = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int e = 1; e < 10; e++) begin
            host_we = (e == 3); host_addr = AW'(30); host_wdata = TW'(9);
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        host_we = 1'b0;
        check_val("abort busy_before", busy, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_val("abort busy_fall", busy, 0);
        if (done === 1'b1) ndone++;
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check_val("abort no_done", ndone, 0);
        check_val("abort iter_hold", iter_count, 0);
        host_read(30, v); check_val("abort busy_write", v, 0);

        // Reset in the middle of a run.
        for (int i = 0; i < N; i++) host_write(i, $urandom_range(15, 1));
        @(negedge clk);
        bc_mode = 1'b1; alpha = AL'(9); n_iter = IW'(3); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_val("midrst busy", busy, 0);
        check_val("midrst host_rdata", host_rdata, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) mg[i] = 0;
        check_val("midrst iter_count", iter_count, 0);
        check_val("midrst max_delta", max_delta, 0);
        check_val("midrst converged", converged, 0);
        check_val("midrst done", done, 0);
        check_grid("midrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
